// File: rtl/clean_point_buffer_pkg.sv
// Shared radar definitions for the clean point buffer.
// Holds the point width, the tag field position, the statistics counter
// width and the layout of one FIFO entry (point plus frame-last flag).
package clean_point_buffer_pkg;

   localparam int unsigned POINT_W = 128;
   localparam int unsigned TAG_MSB = 127;
   localparam int unsigned TAG_LSB = 112;
   localparam int unsigned TAG_W   = TAG_MSB - TAG_LSB + 1;
   localparam int unsigned STAT_W  = 16;
   localparam int unsigned ENTRY_W = POINT_W + 1;

   typedef struct packed {
      logic               last;
      logic [POINT_W-1:0] point;
   } fifo_entry_t;

endpackage

// File: rtl/point_fifo_core.sv
// First-word-fall-through FIFO core holding the pointers and occupancy.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset (empties the FIFO)
//   i_push        - write request
//   i_data        - write data
//   i_ready       - consumer ready; head is popped when o_valid && i_ready
//   o_valid       - head entry valid
//   o_data        - head entry, zero while empty
//   o_count       - occupancy, 0..DEPTH
//   o_lost        - write request dropped because the FIFO was full with no pop
module point_fifo_core #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 129
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_lost
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   // Extra pointer MSB separates full (MSBs differ) from empty (equal).
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = i_ready && !w_empty;
   // A pop on the same edge frees the slot the write lands in.
   assign w_push  = i_push && (!w_full || w_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   assign o_valid = !w_empty;
   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_lost  = i_push && !w_push;

endmodule

// File: rtl/clean_point_buffer.sv
// Buffers points from the static clutter filter into a FWFT FIFO.
// Suppressed points (tag == 0) are either discarded and counted or stored,
// depending on DROP_SUPPRESSED. A discarded point that ends a frame is
// replaced by a zero terminator entry so the frame boundary survives.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   valid_in      - clean_point valid (no backpressure)
//   clean_point   - 128-bit point, tag in [127:112]
//   frame_end     - last point of a frame, qualified by valid_in
//   stats_clear   - synchronous clear of drop_count and overflow
//   out_ready     - consumer ready
//   out_valid / out_point / out_last - head entry
//   fifo_count    - occupancy
//   drop_count    - saturating count of discarded suppressed points
//   overflow      - sticky, a write was lost to a full FIFO
module clean_point_buffer
   import clean_point_buffer_pkg::*;
#(
   parameter int unsigned DEPTH           = 16,
   parameter int unsigned DROP_SUPPRESSED = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid_in,
   input  logic [POINT_W-1:0]       clean_point,
   input  logic                     frame_end,
   input  logic                     stats_clear,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [POINT_W-1:0]       out_point,
   output logic                     out_last,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [STAT_W-1:0]        drop_count,
   output logic                     overflow
);

   logic        w_suppressed;
   logic        w_drop;
   logic        w_push;
   logic        w_lost;
   fifo_entry_t w_wr_entry;
   fifo_entry_t w_head;

   assign w_suppressed = valid_in && (clean_point[TAG_MSB:TAG_LSB] == TAG_W'(0));
   assign w_drop       = w_suppressed && (DROP_SUPPRESSED != 0);
   // A dropped frame-ending point still pushes a terminator.
   assign w_push       = valid_in && (!w_drop || frame_end);

   always_comb begin
      w_wr_entry = '0;
      if (w_drop) begin
         w_wr_entry.last  = 1'b1;
         w_wr_entry.point = '0;
      end else begin
         w_wr_entry.last  = frame_end;
         w_wr_entry.point = clean_point;
      end
   end

   point_fifo_core #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_wr_entry),
      .i_ready (out_ready),
      .o_valid (out_valid),
      .o_data  (w_head),
      .o_count (fifo_count),
      .o_lost  (w_lost)
   );

   assign out_point = w_head.point;
   assign out_last  = w_head.last;

   // An event on the same edge as stats_clear wins over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (w_drop) begin
            if (stats_clear)        drop_count <= STAT_W'(1);
            else if (!(&drop_count)) drop_count <= drop_count + STAT_W'(1);
         end else if (stats_clear) begin
            drop_count <= '0;
         end

         if (w_lost)           overflow <= 1'b1;
         else if (stats_clear) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_clean_point_buffer.sv
module tb_clean_point_buffer;

   logic         clk = 1'b0;
   logic         reset;
   logic         valid_in;
   logic [127:0] clean_point;
   logic         frame_end;
   logic         stats_clear;
   logic         out_ready;

   logic         out_valid;
   logic [127:0] out_point;
   logic         out_last;
   logic [4:0]   fifo_count;
   logic [15:0]  drop_count;
   logic         overflow;

   logic         s_out_valid;
   logic [127:0] s_out_point;
   logic         s_out_last;
   logic [4:0]   s_fifo_count;
   logic [15:0]  s_drop_count;
   logic         s_overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   clean_point_buffer #(.DEPTH(16), .DROP_SUPPRESSED(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .valid_in    (valid_in),
      .clean_point (clean_point),
      .frame_end   (frame_end),
      .stats_clear (stats_clear),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_point   (out_point),
      .out_last    (out_last),
      .fifo_count  (fifo_count),
      .drop_count  (drop_count),
      .overflow    (overflow)
   );

   // Second instance stores suppressed points instead of dropping them.
   clean_point_buffer #(.DEPTH(16), .DROP_SUPPRESSED(0)) dut_keep (
      .clk         (clk),
      .reset       (reset),
      .valid_in    (valid_in),
      .clean_point (clean_point),
      .frame_end   (frame_end),
      .stats_clear (stats_clear),
      .out_ready   (out_ready),
      .out_valid   (s_out_valid),
      .out_point   (s_out_point),
      .out_last    (s_out_last),
      .fifo_count  (s_fifo_count),
      .drop_count  (s_drop_count),
      .overflow    (s_overflow)
   );

   function automatic logic [127:0] pt(input logic [15:0] tag, input int unsigned low);
      pt = {tag, 112'(low)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [127:0] p, input logic fe);
      valid_in    = v;
      clean_point = p;
      frame_end   = fe;
   endtask

   logic [127:0] x_pt;

   initial begin
      reset = 1'b1;
      drive(1'b0, '0, 1'b0);
      stats_clear = 1'b0;
      out_ready   = 1'b1;
      tick();
      tick();
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_count", 128'(fifo_count), 128'(0));
      chk("rst_point", out_point, '0);
      chk("rst_last", 128'(out_last), 128'(0));
      chk("rst_drop", 128'(drop_count), 128'(0));
      chk("rst_ovf", 128'(overflow), 128'(0));
      reset = 1'b0;

      // Three tagged points, frame_end on the third, consumer always ready.
      drive(1'b1, pt(16'h0001, 11), 1'b0);
      tick();
      chk("t1_v1", 128'(out_valid), 128'(1));
      chk("t1_p1", out_point, pt(16'h0001, 11));
      chk("t1_l1", 128'(out_last), 128'(0));
      drive(1'b1, pt(16'h0001, 12), 1'b0);
      tick();
      chk("t1_p2", out_point, pt(16'h0001, 12));
      chk("t1_l2", 128'(out_last), 128'(0));
      chk("t1_cnt2", 128'(fifo_count), 128'(1));
      drive(1'b1, pt(16'h0001, 13), 1'b1);
      tick();
      chk("t1_p3", out_point, pt(16'h0001, 13));
      chk("t1_l3", 128'(out_last), 128'(1));
      drive(1'b0, '0, 1'b0);
      tick();
      chk("t1_empty", 128'(out_valid), 128'(0));
      chk("t1_empty_pt", out_point, '0);
      chk("t1_drop", 128'(drop_count), 128'(0));

      // Tag 5, suppressed, suppressed + frame_end -> point, terminator.
      drive(1'b1, pt(16'h0005, 21), 1'b0);
      tick();
      chk("t2_p1", out_point, pt(16'h0005, 21));
      chk("t2_l1", 128'(out_last), 128'(0));
      drive(1'b1, pt(16'h0000, 22), 1'b0);
      tick();
      chk("t2_gap", 128'(out_valid), 128'(0));
      chk("t2_drop1", 128'(drop_count), 128'(1));
      chk("keep_pt", s_out_point, pt(16'h0000, 22));
      chk("keep_v", 128'(s_out_valid), 128'(1));
      chk("keep_drop", 128'(s_drop_count), 128'(0));
      drive(1'b1, pt(16'h0000, 23), 1'b1);
      tick();
      chk("t2_term_v", 128'(out_valid), 128'(1));
      chk("t2_term_pt", out_point, '0);
      chk("t2_term_l", 128'(out_last), 128'(1));
      chk("t2_drop2", 128'(drop_count), 128'(2));
      chk("keep_pt_fe", s_out_point, pt(16'h0000, 23));
      chk("keep_l_fe", 128'(s_out_last), 128'(1));

      // Drop on the same edge as stats_clear wins, then a plain clear.
      drive(1'b1, pt(16'h0000, 24), 1'b0);
      stats_clear = 1'b1;
      tick();
      chk("clr_drop_win", 128'(drop_count), 128'(1));
      drive(1'b0, '0, 1'b0);
      tick();
      chk("clr_drop", 128'(drop_count), 128'(0));
      stats_clear = 1'b0;
      tick();
      chk("t2_drained", 128'(fifo_count), 128'(0));

      // Fill with the consumer stalled, then overflow.
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, pt(16'h0100, 100 + i), 1'b0);
         tick();
      end
      chk("t3_full_cnt", 128'(fifo_count), 128'(16));
      chk("t3_full_ovf", 128'(overflow), 128'(0));
      chk("t3_head", out_point, pt(16'h0100, 100));
      drive(1'b1, pt(16'h0100, 116), 1'b0);
      stats_clear = 1'b1;
      tick();
      chk("t3_ovf_win", 128'(overflow), 128'(1));
      chk("t3_cnt17", 128'(fifo_count), 128'(16));
      stats_clear = 1'b0;
      drive(1'b1, pt(16'h0100, 117), 1'b0);
      tick();
      chk("t3_ovf_sticky", 128'(overflow), 128'(1));
      chk("t3_drop_same", 128'(drop_count), 128'(0));
      chk("t3_head_stall", out_point, pt(16'h0100, 100));
      drive(1'b0, '0, 1'b0);
      stats_clear = 1'b1;
      tick();
      chk("t3_ovf_clr", 128'(overflow), 128'(0));
      stats_clear = 1'b0;

      // Full FIFO: push and pop on the same edge.
      x_pt = pt(16'h0ABC, 999);
      out_ready = 1'b1;
      drive(1'b1, x_pt, 1'b1);
      tick();
      chk("t4_cnt", 128'(fifo_count), 128'(16));
      chk("t4_ovf", 128'(overflow), 128'(0));
      drive(1'b0, '0, 1'b0);
      for (int k = 1; k < 16; k++) begin
         chk($sformatf("t4_seq%0d", k), out_point, pt(16'h0100, 100 + k));
         tick();
      end
      chk("t4_last_pt", out_point, x_pt);
      chk("t4_last_l", 128'(out_last), 128'(1));
      tick();
      chk("t4_empty", 128'(out_valid), 128'(0));

      // Reset with stored entries and a counted drop.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, pt(16'h0200, 200 + i), 1'b0);
         tick();
      end
      drive(1'b1, pt(16'h0000, 205), 1'b0);
      tick();
      drive(1'b0, '0, 1'b0);
      chk("t5_cnt5", 128'(fifo_count), 128'(5));
      chk("t5_drop", 128'(drop_count), 128'(1));
      reset = 1'b1;
      #1;
      chk("t5_rst_v", 128'(out_valid), 128'(0));
      chk("t5_rst_cnt", 128'(fifo_count), 128'(0));
      chk("t5_rst_pt", out_point, '0);
      chk("t5_rst_drop", 128'(drop_count), 128'(0));
      #1;
      reset = 1'b0;
      drive(1'b1, pt(16'h0300, 300), 1'b0);
      tick();
      drive(1'b0, '0, 1'b0);
      chk("t5_post_v", 128'(out_valid), 128'(1));
      chk("t5_post_pt", out_point, pt(16'h0300, 300));
      chk("t5_post_cnt", 128'(fifo_count), 128'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
